// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory bus bridge: FSM encoding, default
// error read value and the bus-word alignment mask.
package dmem_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

  // Clears the byte offset so the bus only ever sees word addresses.
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dmem_bridge_bus_timer.sv
// Clearable up-counter that flags the last permitted REQ cycle of a bus access.
module bus_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Count REQ cycles without ack; cleared when a new access is launched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + W'(1);
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns core loads/stores into req/ack bus transactions,
// stalls the core until completion, and flags misaligned or timed-out accesses.
//
// state  | meaning
// -------+------------------------------------------
// IDLE   | no transaction; Stall raised by a new access
// REQ    | bus_req high, waiting for bus_ack or timeout
// DONE   | core commit cycle, Stall low
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        err_clr,
  output logic        err_align,
  output logic        err_timeout
);

  logic [1:0] state;
  logic       access;
  logic       misaligned;
  logic       load_in;
  logic       in_idle;
  logic       in_req;
  logic       tmr_clr;
  logic       tmr_inc;
  logic       expire;
  logic       align_set;
  logic       timeout_set;

  assign access      = MemWrite | MemRead;
  assign misaligned  = |Addr[1:0];
  // A simultaneous MemWrite/MemRead is treated as a store.
  assign load_in     = MemRead & ~MemWrite;
  assign in_idle     = (state == S_IDLE);
  assign in_req      = (state == S_REQ);
  assign tmr_clr     = in_idle & access & ~misaligned;
  assign tmr_inc     = in_req & ~bus_ack;
  assign align_set   = in_idle & access & misaligned;
  assign timeout_set = in_req & ~bus_ack & expire;

  assign Stall   = (in_idle & access) | in_req;
  assign bus_req = in_req;

  bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .expire (expire)
  );

  // Sequencer, latched bus request fields and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      ReadData  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            if (misaligned) begin
              if (load_in) ReadData <= ERR_DATA;
              state <= S_DONE;
            end else begin
              bus_we    <= MemWrite;
              bus_addr  <= Addr & WORD_MASK;
              bus_wdata <= WriteData;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            if (!bus_we) ReadData <= bus_rdata;
            state <= S_DONE;
          end else if (expire) begin
            if (!bus_we) ReadData <= ERR_DATA;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error beats a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (align_set)    err_align <= 1'b1;
      else if (err_clr) err_align <= 1'b0;
      if (timeout_set)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with a ReadData scoreboard.
module tb_dmem_bridge;
  import dmem_pkg::*;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = ERR_DATA_DEFAULT;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] Addr, WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, err_clr, err_align, err_timeout;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rd = 32'h0;
  int          txn_cnt  = 0;
  logic        req_q    = 1'b0;
  int          t0;

  dmem_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .err_clr    (err_clr),
    .err_align  (err_align),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Count bus transactions by rising edges of bus_req.
  always @(negedge clk) begin
    if (bus_req && !req_q) txn_cnt++;
    req_q = bus_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one access and follows it to its DONE cycle (returns at that negedge).
  // ack_n = REQ cycle carrying bus_ack; 0 means never acknowledge.
  task automatic run_access(input string tag, input logic we, input logic rd,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int ack_n, input logic [31:0] rdata);
    int          stalls = 0;
    int          reqs   = 0;
    int          exp_stall, exp_reqs;
    logic        done   = 1'b0;
    logic        mis;
    logic [31:0] exp_addr;
    mis       = (a[1:0] != 2'b00);
    exp_addr  = {a[31:2], 2'b00};
    MemWrite  = we;
    MemRead   = rd;
    Addr      = a;
    WriteData = wd;
    if (mis) begin
      exp_stall = 1; exp_reqs = 0;
    end else if (ack_n >= 1 && ack_n <= TO) begin
      exp_stall = ack_n + 1; exp_reqs = ack_n;
    end else begin
      exp_stall = TO + 1; exp_reqs = TO;
    end
    if (rd && !we) model_rd = (mis || ack_n < 1 || ack_n > TO) ? ERR : rdata;
    exp_q.push_back(model_rd);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!Stall) done = 1'b1;
      else begin
        stalls++;
        if (bus_req) begin
          reqs++;
          check({tag, "_bus_addr"}, bus_addr, exp_addr);
          check({tag, "_bus_we"}, {31'b0, bus_we}, {31'b0, we});
          if (we) check({tag, "_bus_wdata"}, bus_wdata, wd);
          bus_ack   = (reqs == ack_n);
          bus_rdata = bus_ack ? rdata : $urandom;
        end
        @(posedge clk);
        #1 bus_ack = 1'b0;
      end
    end
    check({tag, "_reached_done"}, {31'b0, done}, 32'd1);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({tag, "_req_cycles"}, 32'(reqs), 32'(exp_reqs));
    check({tag, "_read_data"}, ReadData, exp_q.pop_front());
  endtask

  task automatic end_access();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; Addr = '0; WriteData = '0;
    bus_rdata = '0; bus_ack = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read_data", ReadData, 32'h0);
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_stall", {31'b0, Stall}, 32'd0);
    check("rst_errs", {30'b0, err_align, err_timeout}, 32'd0);
    MemRead = 1'b1;
    #1 check("rst_stall_follows_in", {31'b0, Stall}, 32'd1);
    MemRead = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    run_access("rd0", 1'b0, 1'b1, 32'h0000_0040, 32'h1111_2222, 1, 32'h1234_5678);
    end_access();

    run_access("wr", 1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_F00D, 3, 32'h0BAD_0BAD);
    end_access();

    run_access("mis", 1'b0, 1'b1, 32'h0000_0041, 32'h0, 1, 32'h9999_9999);
    check("mis_err_align", {31'b0, err_align}, 32'd1);
    end_access();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("clr_err_align", {31'b0, err_align}, 32'd0);

    t0 = txn_cnt;
    run_access("b2b0", 1'b0, 1'b1, 32'h0000_0010, 32'h0, 2, 32'hAAAA_0001);
    run_access("b2b1", 1'b0, 1'b1, 32'h0000_0014, 32'h0, 1, 32'hBBBB_0002);
    end_access();
    repeat (3) @(posedge clk);
    #1 check("b2b_txn_count", 32'(txn_cnt - t0), 32'd2);

    run_access("to", 1'b0, 1'b1, 32'h0000_0030, 32'h0, 0, 32'h0);
    check("to_err_timeout", {31'b0, err_timeout}, 32'd1);
    end_access();
    t0 = txn_cnt;
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    check("spur_stall", {31'b0, Stall}, 32'd0);
    @(posedge clk);
    #1 bus_ack = 1'b0;
    @(negedge clk);
    check("spur_bus_req", {31'b0, bus_req}, 32'd0);
    check("spur_read_data", ReadData, model_rd);
    check("spur_txn_count", 32'(txn_cnt - t0), 32'd0);

    MemWrite = 1'b1; Addr = 32'h0000_0020; WriteData = 32'h55AA_55AA;
    for (int c = 0; c < 10 && !bus_req; c++) @(negedge clk);
    check("rstreq_seen_req", {31'b0, bus_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstreq_bus_req", {31'b0, bus_req}, 32'd0);
    check("rstreq_bus_we", {31'b0, bus_we}, 32'd0);
    check("rstreq_bus_addr", bus_addr, 32'h0);
    check("rstreq_bus_wdata", bus_wdata, 32'h0);
    check("rstreq_read_data", ReadData, 32'h0);
    check("rstreq_errs", {30'b0, err_align, err_timeout}, 32'd0);
    check("rstreq_stall_follows_in", {31'b0, Stall}, 32'd1);
    MemWrite = 1'b0;
    @(negedge clk) reset = 1'b1;
    t0 = txn_cnt;
    repeat (3) @(negedge clk);
    check("rstreq_no_retry_req", {31'b0, bus_req}, 32'd0);
    check("rstreq_no_retry_txn", 32'(txn_cnt - t0), 32'd0);
    check("rstreq_stall_idle", {31'b0, Stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
